// File: rtl/dac_pkg.sv
// Shared types and code-conversion helpers for the TDM DAC front end.
package dac_pkg;

    localparam int CONV_W = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Works on the low dw bits of a CONV_W-wide value; callers cast the result back to their width.
    function automatic logic [CONV_W-1:0] conv(input logic [CONV_W-1:0] x, input int dw, input logic fmt);
        logic [CONV_W-1:0] msb_m;
        logic [CONV_W-1:0] lo_m;
        msb_m = 32'd1 << (dw - 1);
        lo_m  = msb_m - 32'd1;
        if (fmt == 1'b0) begin
            conv = ((~x) & msb_m) | (x & lo_m);
        end else begin
            conv = (x & msb_m) | ((~x) & lo_m);
        end
    endfunction

    function automatic logic [CONV_W-1:0] midscale(input int dw, input logic fmt);
        return conv(32'd0, dw, fmt);
    endfunction

endpackage

// File: rtl/dac_ch_capture.sv
// One channel: capture register with fresh flag, per-frame snapshot register and sticky underrun flag.
module dac_ch_capture
    import dac_pkg::*;
#(
    parameter int DW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [DW-1:0] dat_i,
    input  logic          snap_i,
    input  logic          run_i,
    input  logic          ur_mode_i,
    input  logic          ur_clr_i,
    output logic [DW-1:0] frame_o,
    output logic          underrun_o
);

    logic [DW-1:0] capture_q, capture_d;
    logic [DW-1:0] frame_q, frame_d;
    logic          fresh_q, fresh_d;
    logic          underrun_q, underrun_d;
    logic          ur_set_s;

    // Capture, snapshot and underrun next-state; a strobe coinciding with the snapshot bypasses into the frame.
    always_comb begin
        capture_d  = capture_q;
        frame_d    = frame_q;
        fresh_d    = fresh_q;
        ur_set_s   = 1'b0;
        if (en_i) begin
            capture_d = dat_i;
        end else begin
            capture_d = capture_q;
        end
        if (snap_i) begin
            fresh_d  = 1'b0;
            ur_set_s = run_i & ~fresh_q & ~en_i;
            if (en_i) begin
                frame_d = dat_i;
            end else if (fresh_q) begin
                frame_d = capture_q;
            end else if (ur_mode_i) begin
                frame_d = '0;
            end else begin
                frame_d = frame_q;
            end
        end else if (en_i) begin
            fresh_d = 1'b1;
        end else begin
            fresh_d = fresh_q;
        end
        if (ur_set_s) begin
            underrun_d = 1'b1;
        end else if (ur_clr_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            capture_q  <= '0;
            frame_q    <= '0;
            fresh_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            capture_q  <= capture_d;
            frame_q    <= frame_d;
            fresh_q    <= fresh_d;
            underrun_q <= underrun_d;
        end
    end

    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

endmodule

// File: rtl/dac_tdm_mux.sv
// Time-multiplexes NCH snapshotted sample streams onto one DAC bus, with post-reset DAC init sequencing.
module dac_tdm_mux
    import dac_pkg::*;
#(
    parameter int  DW         = 14,
    parameter int  NCH        = 2,
    parameter int  RST_CYCLES = 16,
    localparam int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              dac_clk_i,
    input  logic              dac_rst_i,
    input  logic [NCH*DW-1:0] ch_dat_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic              fmt_i,
    input  logic              ur_mode_i,
    input  logic              ur_clr_i,
    output logic [DW-1:0]     dac_dat_o,
    output logic [SW-1:0]     dac_sel_o,
    output logic              dac_wrt_o,
    output logic              dac_rst_o,
    output logic              frame_o,
    output logic [NCH-1:0]    underrun_o
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          snap_s;
    logic          run_s;
    logic [DW-1:0] frame_arr_s [NCH];
    logic [DW-1:0] mux_s;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          wrt_q, wrt_d;
    logic          drst_q, drst_d;
    logic          frm_q, frm_d;

    // FSM, init counter and slot counter; the snapshot fires on the last INIT cycle and on every last slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        snap_s  = 1'b0;
        run_s   = 1'b0;
        case (state_q)
            INIT: begin
                slot_d = '0;
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    snap_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (slot_q == SW'(NCH - 1)) begin
                    slot_d = '0;
                    snap_s = 1'b1;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                slot_d  = '0;
            end
        endcase
    end

    // Sequencing state registers.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        dac_ch_capture #(.DW(DW)) u_cap (
            .clk_i      (dac_clk_i),
            .rst_i      (dac_rst_i),
            .en_i       (ch_en_i[k]),
            .dat_i      (ch_dat_i[k*DW +: DW]),
            .snap_i     (snap_s),
            .run_i      (run_s),
            .ur_mode_i  (ur_mode_i),
            .ur_clr_i   (ur_clr_i),
            .frame_o    (frame_arr_s[k]),
            .underrun_o (underrun_o[k])
        );
    end

    // Channel select mux and output code formation.
    always_comb begin
        mux_s = '0;
        for (int k = 0; k < NCH; k++) begin
            mux_s = (slot_q == SW'(k)) ? frame_arr_s[k] : mux_s;
        end
        if (state_q == RUN) begin
            dat_d  = DW'(conv(CONV_W'(mux_s), DW, fmt_i));
            sel_d  = slot_q;
            wrt_d  = 1'b1;
            drst_d = 1'b0;
            frm_d  = (slot_q == '0);
        end else begin
            dat_d  = DW'(midscale(DW, fmt_i));
            sel_d  = '0;
            wrt_d  = 1'b0;
            drst_d = 1'b1;
            frm_d  = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            dat_q  <= DW'(midscale(DW, 1'b0));
            sel_q  <= '0;
            wrt_q  <= 1'b0;
            drst_q <= 1'b1;
            frm_q  <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            sel_q  <= sel_d;
            wrt_q  <= wrt_d;
            drst_q <= drst_d;
            frm_q  <= frm_d;
        end
    end

    assign dac_dat_o = dat_q;
    assign dac_sel_o = sel_q;
    assign dac_wrt_o = wrt_q;
    assign dac_rst_o = drst_q;
    assign frame_o   = frm_q;

endmodule

// File: tb/tb_dac_tdm_mux.sv
// Scoreboard bench for dac_tdm_mux: a frame-position reference model predicts every output cycle.
module tb_dac_tdm_mux;

    localparam int DW   = 14;
    localparam int NCH  = 3;
    localparam int RST  = 4;
    localparam int SW   = 2;
    localparam int MID  = 1 << (DW - 1);
    localparam int MASK = (1 << DW) - 1;

    logic              clk = 1'b0;
    logic              dac_rst_i;
    logic [NCH*DW-1:0] ch_dat_i;
    logic [NCH-1:0]    ch_en_i;
    logic              fmt_i, ur_mode_i, ur_clr_i;
    logic [DW-1:0]     dac_dat_o;
    logic [SW-1:0]     dac_sel_o;
    logic              dac_wrt_o, dac_rst_o, frame_o;
    logic [NCH-1:0]    underrun_o;

    always #5 clk = ~clk;

    dac_tdm_mux #(.DW(DW), .NCH(NCH), .RST_CYCLES(RST)) dut (
        .dac_clk_i  (clk),
        .dac_rst_i  (dac_rst_i),
        .ch_dat_i   (ch_dat_i),
        .ch_en_i    (ch_en_i),
        .fmt_i      (fmt_i),
        .ur_mode_i  (ur_mode_i),
        .ur_clr_i   (ur_clr_i),
        .dac_dat_o  (dac_dat_o),
        .dac_sel_o  (dac_sel_o),
        .dac_wrt_o  (dac_wrt_o),
        .dac_rst_o  (dac_rst_o),
        .frame_o    (frame_o),
        .underrun_o (underrun_o)
    );

    typedef struct {
        logic [DW-1:0]  dat;
        logic [SW-1:0]  sel;
        logic           wrt;
        logic           rst;
        logic           frm;
        logic [NCH-1:0] ur;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: p counts cycles since reset release; frames are derived from p directly.
    int   p;
    int   latest [NCH];
    bit   have   [NCH];
    int   frame_v[NCH];
    bit   sticky [NCH];

    // Stimulus for the next cycle
    bit             r_v, f_v, um_v, clr_v;
    logic [NCH-1:0] en_v;
    int             val_v[NCH];

    function automatic int code(input int x, input bit f);
        return f ? ((MID - 1 - x) & MASK) : ((x + MID) & MASK);
    endfunction

    function automatic bit is_snap(input int ph);
        return (ph == RST - 1) || (ph >= RST && ((ph - RST) % NCH) == NCH - 1);
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(0, MASK)) - MID;
    endfunction

    task automatic step();
        exp_t e;
        bit   snap, set;
        int   s;
        dac_rst_i = r_v;
        ch_en_i   = en_v;
        fmt_i     = f_v;
        ur_mode_i = um_v;
        ur_clr_i  = clr_v;
        for (int k = 0; k < NCH; k++) ch_dat_i[k*DW +: DW] = DW'(val_v[k]);
        if (r_v) begin
            e.dat = DW'(MID); e.sel = '0; e.wrt = 1'b0; e.rst = 1'b1; e.frm = 1'b0; e.ur = '0;
            p = 0;
            for (int k = 0; k < NCH; k++) begin
                latest[k] = 0; have[k] = 1'b0; frame_v[k] = 0; sticky[k] = 1'b0;
            end
        end else begin
            if (p < RST) begin
                e.dat = DW'(code(0, f_v)); e.sel = '0; e.wrt = 1'b0; e.rst = 1'b1; e.frm = 1'b0;
            end else begin
                s = (p - RST) % NCH;
                e.dat = DW'(code(frame_v[s], f_v)); e.sel = SW'(s);
                e.wrt = 1'b1; e.rst = 1'b0; e.frm = (s == 0);
            end
            snap = is_snap(p);
            for (int k = 0; k < NCH; k++) begin
                set = 1'b0;
                if (snap) begin
                    if (en_v[k])       frame_v[k] = val_v[k];
                    else if (have[k])  frame_v[k] = latest[k];
                    else if (um_v)     frame_v[k] = 0;
                    set = (p >= RST) && !have[k] && !en_v[k];
                    have[k] = 1'b0;
                    if (en_v[k]) latest[k] = val_v[k];
                end else if (en_v[k]) begin
                    latest[k] = val_v[k];
                    have[k]   = 1'b1;
                end
                if (set)        sticky[k] = 1'b1;
                else if (clr_v) sticky[k] = 1'b0;
                e.ur[k] = sticky[k];
            end
            p++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Strobe channels in 'mask' on every non-snapshot cycle with ch0=v0, ch1=v1, others random.
    task automatic frames(input int n, input logic [NCH-1:0] mask, input int v0, input int v1);
        for (int i = 0; i < n; i++) begin
            en_v     = is_snap(p) ? '0 : mask;
            val_v[0] = v0;
            val_v[1] = v1;
            for (int k = 2; k < NCH; k++) val_v[k] = rnd_val();
            step();
        end
    endtask

    // Monitor: compare every output cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (dac_dat_o !== e.dat || dac_sel_o !== e.sel || dac_wrt_o !== e.wrt ||
                dac_rst_o !== e.rst || frame_o !== e.frm || underrun_o !== e.ur) begin
                n_fail++;
                $display("FAIL out t=%0t: got dat=%h sel=%0d wrt=%b rst=%b frm=%b ur=%b, want dat=%h sel=%0d wrt=%b rst=%b frm=%b ur=%b",
                         $time, dac_dat_o, dac_sel_o, dac_wrt_o, dac_rst_o, frame_o, underrun_o,
                         e.dat, e.sel, e.wrt, e.rst, e.frm, e.ur);
            end
        end
    end

    initial begin
        r_v = 1'b1; f_v = 1'b0; um_v = 1'b0; clr_v = 1'b0; en_v = '0;
        for (int k = 0; k < NCH; k++) val_v[k] = 0;
        p = 0;
        step();
        step();
        r_v = 1'b0;
        frames(12, '1, 100, -1);
        f_v = 1'b1;
        frames(12, '1, 100, -1);
        f_v = 1'b0;
        frames(12, 3'b101, 100, -1);
        um_v = 1'b1;
        frames(12, 3'b101, 100, -1);
        clr_v = 1'b1;
        frames(9, 3'b101, 200, -1);
        frames(6, '1, 200, -7);
        clr_v = 1'b0;
        um_v  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            en_v     = is_snap(p) ? 3'b001 : 3'b110;
            val_v[0] = 5;
            val_v[1] = rnd_val();
            val_v[2] = rnd_val();
            step();
        end
        frames(9, 3'b110, 0, 33);
        r_v = 1'b1;
        step();
        r_v = 1'b0;
        frames(15, '1, -8192, 8191);
        for (int i = 0; i < 3000; i++) begin
            r_v = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) f_v  = ~f_v;
            if ($urandom_range(0, 49) == 0) um_v = ~um_v;
            clr_v = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NCH; k++) begin
                en_v[k]  = ($urandom_range(0, 4) < 2);
                val_v[k] = rnd_val();
            end
            step();
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
